// File: rtl/dmem_ctrl.sv
// Data-memory access controller: fixed-latency reads and single-cycle writes
// against a synchronous pixel RAM, with range checking and a done handshake.
module dmem_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clock,
    input  logic              rst,
    input  logic [31:0]       abus,
    input  logic [31:0]       wdata,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic [31:0]       rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic [ADDR_W-1:0]   mem_addr_r, addr_next_s;
    logic [DATA_W-1:0]   mem_din_r, din_next_s;
    logic [31:0]         rdata_r, rdata_next_s;
    logic                mem_en_r, en_next_s;
    logic                mem_we_r, we_next_s;
    logic                busy_r, done_r, addr_err_r, err_next_s;
    logic                out_of_range_s;
    logic                unused_wdata_s;

    // Any address bit above the RAM range rejects the request.
    assign out_of_range_s = ((abus >> ADDR_W) != 32'd0);
    assign unused_wdata_s = ^(wdata >> DATA_W);

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        addr_next_s  = mem_addr_r;
        din_next_s   = mem_din_r;
        rdata_next_s = rdata_r;
        en_next_s    = 1'b0;
        we_next_s    = 1'b0;
        err_next_s   = 1'b0;
        case (state_r)
            // FIN also samples so a held request starts with no dead cycle.
            IDLE, FIN: begin
                state_next_s = IDLE;
                if (mem_wr || mem_rd) begin
                    if (out_of_range_s) begin
                        err_next_s = 1'b1;
                    end else if (mem_wr) begin
                        state_next_s = WR;
                        addr_next_s  = abus[ADDR_W-1:0];
                        din_next_s   = wdata[DATA_W-1:0];
                        en_next_s    = 1'b1;
                        we_next_s    = 1'b1;
                    end else begin
                        state_next_s = RD_WAIT;
                        addr_next_s  = abus[ADDR_W-1:0];
                        cnt_next_s   = CNT_W'(LATENCY - 1);
                        en_next_s    = 1'b1;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_r == '0) begin
                    rdata_next_s = 32'(mem_dout);
                    state_next_s = FIN;
                end else begin
                    cnt_next_s = cnt_r - CNT_W'(1);
                    en_next_s  = 1'b1;
                end
            end
            WR: begin
                state_next_s = FIN;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any access in flight.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            mem_addr_r <= '0;
            mem_din_r  <= '0;
            rdata_r    <= 32'd0;
            mem_en_r   <= 1'b0;
            mem_we_r   <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            mem_addr_r <= addr_next_s;
            mem_din_r  <= din_next_s;
            rdata_r    <= rdata_next_s;
            mem_en_r   <= en_next_s;
            mem_we_r   <= we_next_s;
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_next_s == FIN);
            addr_err_r <= err_next_s;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign addr_err = addr_err_r;
    assign rdata    = rdata_r;
    assign mem_en   = mem_en_r;
    assign mem_we   = mem_we_r;
    assign mem_addr = mem_addr_r;
    assign mem_din  = mem_din_r;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed accesses, a timeline model of each access,
// a per-cycle compare process and hand-computed literal expectations.
module tb_dmem_ctrl;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] abus = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic        busy, done, addr_err, mem_en, mem_we;
    logic [31:0] rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout = 8'd0;

    int n_chk = 0;
    int n_pass = 0;

    dmem_ctrl #(.ADDR_W(16), .DATA_W(8), .LATENCY(LAT)) dut (
        .clock(clock), .rst(rst), .abus(abus), .wdata(wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .busy(busy), .done(done),
        .addr_err(addr_err), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clock = ~clock;

    // Synchronous RAM seen by the DUT: one register stage on the read path.
    logic [7:0] bram [0:65535] = '{default: 8'h00};
    always @(posedge clock) begin
        if (mem_en && mem_we) bram[mem_addr] <= mem_din;
        mem_dout <= bram[mem_addr];
    end

    // Model: an accepted access runs a timeline of len cycles (ph = 0..len-1).
    logic [7:0]  mram [0:65535] = '{default: 8'h00};
    int          ph = -1;
    int          len = 0;
    bit          m_wr = 1'b0;
    bit          e_err = 1'b0;
    logic [31:0] e_rdata = 32'd0;
    logic [15:0] e_addr = 16'd0;
    logic [7:0]  e_din = 8'd0;

    always @(posedge clock or posedge rst) begin : model
        int nph;
        bit take;
        if (rst) begin
            ph <= -1; len <= 0; m_wr <= 1'b0; e_err <= 1'b0;
            e_rdata <= 32'd0; e_addr <= 16'd0; e_din <= 8'd0;
        end else begin
            take = (ph < 0) || (ph == len - 1);
            nph  = take ? -1 : ph + 1;
            e_err <= 1'b0;
            if (ph == 0 && m_wr) mram[e_addr] <= e_din;
            if (ph >= 0 && !m_wr && ph == LAT - 1) e_rdata <= {24'd0, mram[e_addr]};
            if (take && (mem_rd || mem_wr)) begin
                if (abus[31:16] != 16'd0) begin
                    e_err <= 1'b1;
                end else begin
                    nph    = 0;
                    m_wr   <= mem_wr;
                    len    <= mem_wr ? 2 : LAT + 1;
                    e_addr <= abus[15:0];
                    if (mem_wr) e_din <= wdata[7:0];
                end
            end
            ph <= nph;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle compare of every DUT output against the model.
    always @(negedge clock) begin
        if (!rst) begin
            chk("m_busy", {31'd0, busy}, {31'd0, ph >= 0});
            chk("m_done", {31'd0, done}, {31'd0, ph >= 0 && ph == len - 1});
            chk("m_err", {31'd0, addr_err}, {31'd0, e_err});
            chk("m_en", {31'd0, mem_en}, {31'd0, ph >= 0 && (m_wr ? ph == 0 : ph < LAT)});
            chk("m_we", {31'd0, mem_we}, {31'd0, ph == 0 && m_wr});
            chk("m_rdata", rdata, e_rdata);
            chk("m_addr", {16'd0, mem_addr}, {16'd0, e_addr});
            chk("m_din", {24'd0, mem_din}, {24'd0, e_din});
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int ndone;
        int nerr;
        repeat (2) @(posedge clock);
        #1 rst = 1'b0;

        // Reset asserted in the middle of a write
        abus = 32'h20; wdata = 32'h55; mem_wr = 1'b1; tick(); mem_wr = 1'b0;
        chk("pre_rst_we", {31'd0, mem_we}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, addr_err}, 32'd0);
        chk("rst_en", {31'd0, mem_en}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_din", {24'd0, mem_din}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        @(posedge clock);
        #1 rst = 1'b0;

        // Write: only the low byte of wdata reaches the RAM
        abus = 32'h0000_0010; wdata = 32'hDEAD_BEA5; mem_wr = 1'b1; tick(); mem_wr = 1'b0;
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_addr", {16'd0, mem_addr}, 32'h0010);
        chk("wr_din", {24'd0, mem_din}, 32'hA5);
        chk("wr_done_early", {31'd0, done}, 32'd0);
        tick();
        chk("wr_done", {31'd0, done}, 32'd1);
        chk("wr_we_off", {31'd0, mem_we}, 32'd0);
        chk("wr_rdata", rdata, 32'd0);
        tick();
        chk("wr_idle", {31'd0, busy}, 32'd0);

        // Store 0x3C at 0x10, then read it back
        wdata = 32'h3C; mem_wr = 1'b1; tick(); mem_wr = 1'b0;
        tick(); tick();
        mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        chk("rd_busy0", {31'd0, busy}, 32'd1);
        chk("rd_en0", {31'd0, mem_en}, 32'd1);
        tick();
        chk("rd_done1", {31'd0, done}, 32'd0);
        tick();
        chk("rd_done2", {31'd0, done}, 32'd1);
        chk("rd_rdata", rdata, 32'h0000_003C);
        chk("rd_busy2", {31'd0, busy}, 32'd1);
        tick();
        chk("rd_idle", {31'd0, busy}, 32'd0);

        // Read and write together: the write wins
        abus = 32'h30; wdata = 32'h11; mem_rd = 1'b1; mem_wr = 1'b1; tick();
        mem_rd = 1'b0; mem_wr = 1'b0;
        chk("cf_we", {31'd0, mem_we}, 32'd1);
        tick(); tick();
        chk("cf_rdata", rdata, 32'h3C);

        // Second read issued while busy is ignored
        abus = 32'h10; mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        ndone = 0;
        abus = 32'h30; mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        ndone += int'(done);
        for (int i = 0; i < 6; i++) begin
            tick();
            ndone += int'(done);
        end
        chk("busy_ign_done", ndone, 32'd1);
        chk("busy_ign_rdata", rdata, 32'h3C);

        // Out-of-range address
        abus = 32'h0001_0000; mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        chk("oor_err", {31'd0, addr_err}, 32'd1);
        chk("oor_en", {31'd0, mem_en}, 32'd0);
        chk("oor_busy", {31'd0, busy}, 32'd0);
        ndone = 0; nerr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ndone += int'(done);
            nerr += int'(addr_err);
        end
        chk("oor_done", ndone, 32'd0);
        chk("oor_err_once", nerr, 32'd0);
        chk("oor_rdata", rdata, 32'h3C);

        // Reset during a read, then a clean read
        abus = 32'h30; mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rrd_busy", {31'd0, busy}, 32'd0);
        chk("rrd_en", {31'd0, mem_en}, 32'd0);
        chk("rrd_done", {31'd0, done}, 32'd0);
        @(posedge clock);
        #1 rst = 1'b0;
        mem_rd = 1'b1; tick(); mem_rd = 1'b0;
        tick(); tick();
        chk("rrd2_done", {31'd0, done}, 32'd1);
        chk("rrd2_rdata", rdata, 32'h11);
        tick();

        // Back-to-back: read held through FIN starts on the edge ending FIN
        abus = 32'h1; wdata = 32'h7F; mem_wr = 1'b1; tick(); mem_wr = 1'b0;
        mem_rd = 1'b1; tick();
        chk("b2b_fin", {31'd0, done}, 32'd1);
        tick(); mem_rd = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_en", {31'd0, mem_en}, 32'd1);
        chk("b2b_we", {31'd0, mem_we}, 32'd0);
        tick(); tick();
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_rdata", rdata, 32'h7F);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
